// File: rtl/egress_arbiter.sv
// egress_arbiter: round-robin packet arbiter granting one of N_PORTS ingress ports to a single egress.
// Ports: clk; reset_n (async, active-low); ingress_valid/ingress_eop (per-port beat valid / end-of-packet);
//   egress_ready (downstream accept); selected_ingress (registered data-mux select); ingress_ready
//   (one-hot backpressure); egress_valid/egress_eop (egress beat); busy (grant held);
//   timeout_err (stall watchdog pulse, present only when PKT_TIMEOUT_EN is defined).
// Optional macro PKT_TIMEOUT_EN compiles in a stall watchdog that revokes a grant after
//   TIMEOUT_CYCLES cycles without a transfer.
module egress_arbiter #(
  parameter int N_PORTS = 4,
  parameter int IDX_WIDTH = $clog2(N_PORTS),
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_PORTS-1:0]   ingress_valid,
  input  logic [N_PORTS-1:0]   ingress_eop,
  input  logic                 egress_ready,
  output logic [IDX_WIDTH-1:0] selected_ingress,
  output logic [N_PORTS-1:0]   ingress_ready,
  output logic                 egress_valid,
  output logic                 egress_eop,
`ifdef PKT_TIMEOUT_EN
  output logic                 timeout_err,
`endif
  output logic                 busy
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state;
  logic [IDX_WIDTH-1:0] r_sel, r_last, w_pick, w_idx;
  logic w_xfer, w_tmo;
  // Walk from the farthest candidate to the nearest so the port right after r_last wins.
  always_comb begin
    w_pick = r_last;
    w_idx = '0;
    for (int k = N_PORTS; k >= 1; k--) begin
      w_idx = IDX_WIDTH'((int'(r_last) + k) % N_PORTS);
      if (ingress_valid[w_idx]) w_pick = w_idx;
    end
  end
  assign busy = (r_state == BUSY);
  assign selected_ingress = r_sel;
  assign egress_valid = busy & ingress_valid[r_sel];
  assign egress_eop = egress_valid & ingress_eop[r_sel];
  assign ingress_ready = (busy & egress_ready) ? N_PORTS'(1) << r_sel : '0;
  assign w_xfer = egress_valid & egress_ready;
`ifdef PKT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic r_tmo;
  // Fires on the stall cycle that would bring the count to TIMEOUT_CYCLES.
  assign w_tmo = busy & ~w_xfer & (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = r_tmo;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else begin
      r_tmo <= w_tmo;
      r_cnt <= (!busy || w_xfer || w_tmo) ? '0 : r_cnt + 1'b1;
    end
`else
  assign w_tmo = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_sel <= '0;
      r_last <= IDX_WIDTH'(N_PORTS - 1);
    end else if (r_state == IDLE) begin
      if (|ingress_valid) begin
        r_sel <= w_pick;
        r_state <= BUSY;
      end
    end else if ((w_xfer & egress_eop) | w_tmo) begin
      r_state <= IDLE;
      r_last <= r_sel;
    end
endmodule

// File: tb/tb_egress_arbiter.sv
`timescale 1ns/1ps
module tb_egress_arbiter;
  logic clk = 0, reset_n = 0, egress_ready = 0;
  logic [3:0] ingress_valid = 0, ingress_eop = 0, ingress_ready;
  logic [1:0] selected_ingress;
  logic egress_valid, egress_eop, busy;
`ifdef PKT_TIMEOUT_EN
  logic timeout_err;
`endif
  int checks = 0, errors = 0;
  logic [1:0] exp_g[$];
  logic [2:0] exp_x[$];
  int beat[4] = '{0, 0, 0, 0};
  logic prev_busy = 0, after_eop = 0;

  always #5 clk = ~clk;

  egress_arbiter #(.N_PORTS(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ingress_valid(ingress_valid),
    .ingress_eop(ingress_eop),
    .egress_ready(egress_ready),
    .selected_ingress(selected_ingress),
    .ingress_ready(ingress_ready),
    .egress_valid(egress_valid),
    .egress_eop(egress_eop),
`ifdef PKT_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] v, input logic [3:0] e, input logic r);
    ingress_valid = v;
    ingress_eop = e;
    egress_ready = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rr_eop();
    logic [3:0] e;
    for (int p = 0; p < 4; p++) e[p] = (beat[p] % 2 == 1);
    return e;
  endfunction

  // Monitor: pops expected grants on busy rising and expected beats on every transfer.
  always @(negedge clk) begin
    if (reset_n) begin
      if (after_eop) chk("idle_after_eop", busy, 0);
      if (busy && !prev_busy) begin
        if (exp_g.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got port %0d expected none", selected_ingress);
        end else chk("grant", selected_ingress, exp_g.pop_front());
      end
      if (egress_valid && egress_ready) begin
        beat[selected_ingress]++;
        if (exp_x.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got port %0d eop %0b expected none", selected_ingress, egress_eop);
        end else chk("xfer", {selected_ingress, egress_eop}, exp_x.pop_front());
      end
    end
    prev_busy <= reset_n && busy;
    after_eop <= reset_n && egress_valid && egress_ready && egress_eop;
  end

  initial begin
    reset_n = 0;
    ingress_valid = 4'($urandom);
    ingress_eop = 4'($urandom);
    egress_ready = 1;
    #12;
    chk("rst_sel", selected_ingress, 0);
    chk("rst_busy", busy, 0);
    chk("rst_evalid", egress_valid, 0);
    chk("rst_eeop", egress_eop, 0);
    chk("rst_iready", ingress_ready, 0);
    @(posedge clk);
    #1;
    reset_n = 1;
    // Round-robin: 2-beat packets from every port, grants 0,1,2,3,0
    for (int p = 0; p < 5; p++) begin
      exp_g.push_back(2'(p % 4));
      exp_x.push_back({2'(p % 4), 1'b0});
      exp_x.push_back({2'(p % 4), 1'b1});
    end
    for (int c = 0; c < 15; c++) begin
      step(4'hF, rr_eop(), 1);
      tick();
      if (c == 0) begin
        chk("rst_first_sel", selected_ingress, 0);
        chk("rst_first_busy", busy, 1);
      end
    end
    step(0, 0, 1);
    tick();
    // Backpressure and bubble on port 2
    exp_g.push_back(2);
    exp_x.push_back({2'd2, 1'b0});
    exp_x.push_back({2'd2, 1'b0});
    exp_x.push_back({2'd2, 1'b1});
    step(4'b0100, 0, 1); tick();
    step(4'b0100, 0, 1); chk("bp_ready_on", ingress_ready, 4'b0100); tick();
    step(4'b0100, 0, 0); chk("bp_ready_off", ingress_ready, 0); tick();
    step(4'b0100, 0, 0); chk("bp_hold", busy, 1); tick();
    step(0, 0, 1);
    chk("bp_bubble_valid", egress_valid, 0);
    chk("bp_bubble_busy", busy, 1);
    chk("bp_bubble_ready", ingress_ready, 4'b0100);
    tick();
    step(4'b0100, 0, 1); tick();
    step(4'b0100, 4'b0100, 1); chk("bp_eop", egress_eop, 1); tick();
    step(0, 0, 0); tick();
    // Port 1 eop accepted while ports 0 and 2 request: port 2 is next
    exp_g.push_back(1);
    exp_x.push_back({2'd1, 1'b1});
    exp_g.push_back(2);
    exp_x.push_back({2'd2, 1'b1});
    step(4'b0010, 0, 1); tick();
    step(4'b0111, 4'b0010, 1); tick();
    step(4'b0101, 0, 1); chk("sim_idle", busy, 0); tick();
    chk("sim_next", selected_ingress, 2);
    step(4'b0100, 4'b0100, 1); tick();
    step(0, 0, 0); tick();
    // Reset in beat 2 of a port 3 packet
    exp_g.push_back(3);
    exp_x.push_back({2'd3, 1'b0});
    step(4'b1000, 0, 1); tick();
    step(4'b1000, 0, 1); tick();
    step(4'b1000, 0, 1);
    chk("mid_busy", busy, 1);
    reset_n = 0;
    #1;
    chk("mid_rst_sel", selected_ingress, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_evalid", egress_valid, 0);
    chk("mid_rst_eeop", egress_eop, 0);
    chk("mid_rst_iready", ingress_ready, 0);
    tick();
    exp_g.push_back(0);
    exp_x.push_back({2'd0, 1'b1});
    step(4'hF, 0, 1);
    reset_n = 1;
    tick();
    chk("mid_regrant_sel", selected_ingress, 0);
    chk("mid_regrant_busy", busy, 1);
    step(4'b0001, 4'b0001, 1); tick();
    step(0, 0, 0); tick();
`ifdef PKT_TIMEOUT_EN
    // Watchdog: port 1 stalls after one beat, grant revoked, port 2 next
    exp_g.push_back(1);
    exp_x.push_back({2'd1, 1'b0});
    exp_g.push_back(2);
    exp_x.push_back({2'd2, 1'b1});
    step(4'b0010, 0, 1); tick();
    step(4'b0010, 0, 1); tick();
    for (int c = 0; c < 8; c++) begin
      step(4'b0110, 0, 0);
      chk("to_err_low", timeout_err, 0);
      chk("to_busy", busy, 1);
      tick();
    end
    chk("to_err_pulse", timeout_err, 1);
    chk("to_idle", busy, 0);
    step(4'b0110, 0, 1); tick();
    chk("to_err_clear", timeout_err, 0);
    chk("to_next", selected_ingress, 2);
    step(4'b0100, 4'b0100, 1); tick();
    step(0, 0, 0); tick();
`endif
    tick();
    tick();
    chk("grant_queue_empty", exp_g.size(), 0);
    chk("xfer_queue_empty", exp_x.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
